// File: rtl/frost_share_reader.sv
// frost_share_reader: collects one secret share per sender from a shared
// share memory. It scans the share-present bitmap for the lowest undelivered
// sender, reads that share, and presents it on a valid/ready handshake. The
// run ends in DONE when every sender has been delivered, or in TIMEOUT when
// no new share appears for too long.
module frost_share_reader #(
    parameter int NUM_NODES      = 4,
    parameter int SCALAR_BITS    = 252,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int AW            = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [NUM_NODES-1:0]   valid_in,
    output logic                   rd_en,
    output logic [AW-1:0]          rd_addr,
    input  logic [SCALAR_BITS-1:0] rd_data,
    output logic                   share_valid,
    input  logic                   share_ready,
    output logic [SCALAR_BITS-1:0] share_data,
    output logic [AW-1:0]          share_sender,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout,
    output logic [NUM_NODES-1:0]   received_mask,
    output logic [15:0]            cycles
);

    localparam int            IW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] TO_LIM = IW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_READ, S_WAIT, S_PRESENT, S_DONE, S_TIMEOUT
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_NODES-1:0]   mask_q, mask_d;
    logic [15:0]            cycles_q, cycles_d;
    logic [IW-1:0]          idle_q, idle_d;
    logic [AW-1:0]          rd_addr_q, rd_addr_d;
    logic [SCALAR_BITS-1:0] share_data_q, share_data_d;
    logic [AW-1:0]          share_sender_q, share_sender_d;

    logic [NUM_NODES-1:0]   eligible;
    logic                   found;
    logic [AW-1:0]          pick;
    logic [IW-1:0]          idle_inc;
    logic                   idle_hit;
    logic [NUM_NODES-1:0]   mask_set;
    logic                   all_set;

    // Lowest-index undelivered sender that has a share ready; mask bits that
    // are already set make later drops of valid_in irrelevant.
    always_comb begin
        eligible = valid_in & ~mask_q;
        found    = |eligible;
        pick     = '0;
        for (int j = NUM_NODES - 1; j >= 0; j--) begin
            if (eligible[j]) pick = AW'(j);
        end
        idle_inc = idle_q + 1'b1;
        idle_hit = (idle_inc >= TO_LIM);
        mask_set = mask_q | (NUM_NODES'(1) << share_sender_q);
        all_set  = &mask_set;
    end

    // State register; reset aborts any in-flight read or handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; start is only looked at in the non-busy states.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_TIMEOUT: if (start) state_d = S_SCAN;
            S_SCAN: begin
                if (found)         state_d = S_READ;
                else if (idle_hit) state_d = S_TIMEOUT;
            end
            S_READ:    state_d = S_WAIT;
            S_WAIT:    state_d = S_PRESENT;
            S_PRESENT: if (share_ready) state_d = all_set ? S_DONE : S_SCAN;
            default:   state_d = S_IDLE;
        endcase
    end

    // Datapath next values: run bookkeeping, read address, captured share.
    always_comb begin
        mask_d         = mask_q;
        cycles_d       = cycles_q;
        idle_d         = idle_q;
        rd_addr_d      = rd_addr_q;
        share_data_d   = share_data_q;
        share_sender_d = share_sender_q;
        if (busy && cycles_q != 16'hFFFF) cycles_d = cycles_q + 16'd1;
        case (state_q)
            S_IDLE, S_DONE, S_TIMEOUT: begin
                if (start) begin
                    mask_d   = '0;
                    cycles_d = '0;
                    idle_d   = '0;
                end
            end
            S_SCAN: begin
                if (found) begin
                    rd_addr_d = pick;
                    idle_d    = '0;
                end else begin
                    idle_d = idle_inc;
                end
            end
            // rd_data answers the READ-cycle strobe here, one cycle later.
            S_WAIT: begin
                share_data_d   = rd_data;
                share_sender_d = rd_addr_q;
            end
            S_PRESENT: if (share_ready) mask_d = mask_set;
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q         <= '0;
            cycles_q       <= '0;
            idle_q         <= '0;
            rd_addr_q      <= '0;
            share_data_q   <= '0;
            share_sender_q <= '0;
        end else begin
            mask_q         <= mask_d;
            cycles_q       <= cycles_d;
            idle_q         <= idle_d;
            rd_addr_q      <= rd_addr_d;
            share_data_q   <= share_data_d;
            share_sender_q <= share_sender_d;
        end
    end

    // Status and strobe outputs decoded from the state.
    always_comb begin
        rd_en       = (state_q == S_READ);
        share_valid = (state_q == S_PRESENT);
        busy        = (state_q == S_SCAN) || (state_q == S_READ) ||
                      (state_q == S_WAIT) || (state_q == S_PRESENT);
        done        = (state_q == S_DONE);
        timeout     = (state_q == S_TIMEOUT);
    end

    assign rd_addr       = rd_addr_q;
    assign share_data    = share_data_q;
    assign share_sender  = share_sender_q;
    assign received_mask = mask_q;
    assign cycles        = cycles_q;

endmodule

// File: tb/tb_frost_share_reader.sv
// Bench for frost_share_reader: directed runs with a scoreboard. Stimulus
// pushes expected sender indices; monitors pop and check on each handshake.
// A second instance with a short idle limit covers the timeout path.
module tb_frost_share_reader;

    localparam int N  = 4;
    localparam int SB = 252;
    localparam int AW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start, ready, rd_en, sv, busy, done, tmo;
    logic [N-1:0]  vin, mask;
    logic [AW-1:0] rd_addr, ssend;
    logic [SB-1:0] rd_data, sdata;
    logic [15:0]   cyc;

    logic          start2, ready2, rd_en2, sv2, busy2, done2, tmo2;
    logic [N-1:0]  vin2, mask2;
    logic [AW-1:0] rd_addr2, ssend2;
    logic [SB-1:0] rd_data2, sdata2;
    logic [15:0]   cyc2;

    int tests = 0;
    int fails = 0;
    int q1[$];
    int q2[$];
    int rd_cnt  = 0;
    int rd_cnt2 = 0;

    frost_share_reader #(.NUM_NODES(N), .SCALAR_BITS(SB)) dut (
        .clk(clk), .rst(rst), .start(start), .valid_in(vin),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .share_valid(sv), .share_ready(ready), .share_data(sdata),
        .share_sender(ssend), .busy(busy), .done(done), .timeout(tmo),
        .received_mask(mask), .cycles(cyc)
    );

    frost_share_reader #(.NUM_NODES(N), .SCALAR_BITS(SB), .TIMEOUT_CYCLES(8)) dut_to (
        .clk(clk), .rst(rst), .start(start2), .valid_in(vin2),
        .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
        .share_valid(sv2), .share_ready(ready2), .share_data(sdata2),
        .share_sender(ssend2), .busy(busy2), .done(done2), .timeout(tmo2),
        .received_mask(mask2), .cycles(cyc2)
    );

    function automatic logic [SB-1:0] mem_word(input int i);
        return {4{63'h1A5A_0000_0000_0000 + 63'(i)}};
    endfunction

    // Share memory: data one cycle after rd_en, junk otherwise.
    always @(posedge clk) begin
        rd_data  <= rd_en  ? mem_word(int'(rd_addr))  : {63{4'hD}};
        rd_data2 <= rd_en2 ? mem_word(int'(rd_addr2)) : {63{4'hD}};
    end

    task automatic chk(input string nm, input logic [SB-1:0] got, input logic [SB-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        chk("wait_done", SB'(done), SB'(1));
    endtask

    // Monitor for the main instance: handshake scoreboard and hold stability.
    logic          prev_hold = 1'b0;
    logic [SB-1:0] prev_d;
    logic [AW-1:0] prev_s;
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (rd_en) rd_cnt++;
            if (sv && prev_hold) begin
                chk("hold_data", sdata, prev_d);
                chk("hold_sender", SB'(ssend), SB'(prev_s));
            end
            if (sv && ready) begin
                if (q1.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_share: got sender %0d expected none", ssend);
                end else begin
                    int e;
                    e = q1.pop_front();
                    chk("share_sender", SB'(ssend), SB'(e));
                    chk("share_data", sdata, mem_word(e));
                end
            end
            prev_hold = sv && !ready;
            prev_d    = sdata;
            prev_s    = ssend;
        end
    end

    // Monitor for the short-timeout instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_en2) rd_cnt2++;
            if (sv2 && ready2) begin
                if (q2.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_share2: got sender %0d expected none", ssend2);
                end else begin
                    int e;
                    e = q2.pop_front();
                    chk("share_sender2", SB'(ssend2), SB'(e));
                    chk("share_data2", sdata2, mem_word(e));
                end
            end
        end
    end

    task automatic check_reset();
        chk("rst_rd_en", SB'(rd_en), '0);
        chk("rst_rd_addr", SB'(rd_addr), '0);
        chk("rst_share_valid", SB'(sv), '0);
        chk("rst_share_data", sdata, '0);
        chk("rst_share_sender", SB'(ssend), '0);
        chk("rst_busy", SB'(busy), '0);
        chk("rst_done", SB'(done), '0);
        chk("rst_timeout", SB'(tmo), '0);
        chk("rst_mask", SB'(mask), '0);
        chk("rst_cycles", SB'(cyc), '0);
        chk("rst_busy2", SB'(busy2), '0);
        chk("rst_mask2", SB'(mask2), '0);
        chk("rst_cycles2", SB'(cyc2), '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        start = 0; ready = 1; vin = '0;
        start2 = 0; ready2 = 1; vin2 = '0;
        rst = 1;
        repeat (2) tick();
        check_reset();
        rst = 0;
        tick();

        // All four senders present, consumer always ready.
        vin = 4'hF; rd_cnt = 0;
        for (int i = 0; i < 4; i++) q1.push_back(i);
        start = 1; tick(); start = 0;
        chk("t1_busy", SB'(busy), SB'(1));
        repeat (15) tick();
        chk("t1_done_c16", SB'(done), SB'(0));
        tick();
        chk("t1_done_c17", SB'(done), SB'(1));
        chk("t1_cycles", SB'(cyc), SB'(16));
        chk("t1_mask", SB'(mask), SB'(4'hF));
        chk("t1_busy_end", SB'(busy), SB'(0));
        chk("t1_rd_cnt", SB'(rd_cnt), SB'(4));
        chk("t1_q_empty", SB'(q1.size()), SB'(0));

        // Restart from DONE with 0101, remaining senders appear at cycle 20.
        vin = 4'h5; rd_cnt = 0;
        q1.push_back(0); q1.push_back(2);
        start = 1; tick(); start = 0;
        chk("t2_done_clr", SB'(done), SB'(0));
        chk("t2_mask_clr", SB'(mask), SB'(0));
        chk("t2_cycles_clr", SB'(cyc), SB'(0));
        repeat (18) tick();
        chk("t2_mask_mid", SB'(mask), SB'(4'h5));
        chk("t2_busy_mid", SB'(busy), SB'(1));
        tick();
        vin = 4'hF;
        q1.push_back(1); q1.push_back(3);
        wait_done(40);
        chk("t2_cycles", SB'(cyc), SB'(27));
        chk("t2_mask", SB'(mask), SB'(4'hF));
        chk("t2_timeout", SB'(tmo), SB'(0));
        chk("t2_q_empty", SB'(q1.size()), SB'(0));

        // Back-pressure for 10 cycles in PRESENT, with a start pulse there.
        vin = 4'hF; ready = 0; rd_cnt = 0;
        for (int i = 0; i < 4; i++) q1.push_back(i);
        start = 1; tick(); start = 0;
        begin
            int n = 0;
            while (!sv && n < 20) begin
                tick();
                n++;
            end
        end
        chk("t3_present", SB'(sv), SB'(1));
        for (int k = 0; k < 10; k++) begin
            chk("t3_valid", SB'(sv), SB'(1));
            chk("t3_data", sdata, mem_word(0));
            chk("t3_sender", SB'(ssend), SB'(0));
            if (k == 5) start = 1;
            tick();
            start = 0;
        end
        chk("t3_rd_cnt", SB'(rd_cnt), SB'(1));
        ready = 1;
        wait_done(40);
        chk("t3_cycles", SB'(cyc), SB'(26));
        chk("t3_mask", SB'(mask), SB'(4'hF));
        chk("t3_q_empty", SB'(q1.size()), SB'(0));

        // Reset asserted during WAIT, then a clean run.
        for (int i = 0; i < 4; i++) q1.push_back(i);
        start = 1; tick(); start = 0;
        tick(); tick();
        chk("t4_in_wait", SB'({busy, sv, rd_en}), SB'(3'b100));
        #2 rst = 1;
        #1 check_reset();
        q1.delete();
        tick();
        rst = 0;
        chk("t4_idle", SB'(busy), SB'(0));
        rd_cnt = 0;
        for (int i = 0; i < 4; i++) q1.push_back(i);
        start = 1; tick(); start = 0;
        repeat (15) tick();
        chk("t4_done_c16", SB'(done), SB'(0));
        tick();
        chk("t4_done_c17", SB'(done), SB'(1));
        chk("t4_cycles", SB'(cyc), SB'(16));
        chk("t4_mask", SB'(mask), SB'(4'hF));
        chk("t4_rd_cnt", SB'(rd_cnt), SB'(4));

        // Idle limit of 8 with only senders 0 and 1 present.
        vin2 = 4'h3; rd_cnt2 = 0;
        q2.push_back(0); q2.push_back(1);
        start2 = 1; tick(); start2 = 0;
        repeat (15) tick();
        chk("t5_tmo_c16", SB'(tmo2), SB'(0));
        chk("t5_busy_c16", SB'(busy2), SB'(1));
        tick();
        chk("t5_tmo_c17", SB'(tmo2), SB'(1));
        chk("t5_done", SB'(done2), SB'(0));
        chk("t5_mask", SB'(mask2), SB'(4'h3));
        chk("t5_cycles", SB'(cyc2), SB'(16));
        chk("t5_rd_cnt", SB'(rd_cnt2), SB'(2));
        chk("t5_q_empty", SB'(q2.size()), SB'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
